// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RISC-V immediate generator with valid/ready skid buffer and flush
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             skid_full_q, skid_full_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic [XLEN-1:0]  imm;
  logic             acc;
  assign in_ready  = !skid_full_q && !RESET;
  assign acc       = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_tag   = out_tag_q;
  // Decode the selected immediate format from the raw instruction word
  always_comb
    imm = in_imm_sel == 3'd0 ? {{(XLEN-12){in_instr[31]}}, in_instr[31:20]} :
          in_imm_sel == 3'd1 ? {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
          in_imm_sel == 3'd2 ? {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
          in_imm_sel == 3'd3 ? {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0} :
          in_imm_sel == 3'd4 ? {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
          in_imm_sel == 3'd5 ? XLEN'(in_instr[19:15]) :
          in_imm_sel == 3'd6 ? (XLEN == 64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20])) :
          '0;
  // Next state of output and skid registers, flush first then skid drain, then new beats
  always_comb begin
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    out_tag_d   = out_tag_q;
    skid_full_d = skid_full_q;
    skid_imm_d  = skid_imm_q;
    skid_tag_d  = skid_tag_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (skid_full_q && (out_ready || !out_valid_q)) begin
      out_valid_d = 1'b1;
      out_imm_d   = skid_imm_q;
      out_tag_d   = skid_tag_q;
      skid_full_d = 1'b0;
    end else if (acc && (!out_valid_q || out_ready)) begin
      out_valid_d = 1'b1;
      out_imm_d   = imm;
      out_tag_d   = in_tag;
    end else if (acc) begin
      skid_full_d = 1'b1;
      skid_imm_d  = imm;
      skid_tag_d  = in_tag;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end
  // State registers with synchronous reset clearing all held beats
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_tag_q   <= '0;
      skid_full_q <= 1'b0;
      skid_imm_q  <= '0;
      skid_tag_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_tag_q   <= out_tag_d;
      skid_full_q <= skid_full_d;
      skid_imm_q  <= skid_imm_d;
      skid_tag_q  <= skid_tag_d;
    end
  end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed checks of imm_gen_stage at XLEN=32 and XLEN=64
module tb_imm_gen_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready;
  logic [31:0] in_instr, in_tag;
  logic [2:0]  in_imm_sel;
  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] out_imm32, out_tag32, out_tag64;
  logic [63:0] out_imm64;
  int          n_tests = 0;
  int          n_fail  = 0;
  always #5 clk = ~clk;
  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .CLK(clk), .RESET(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32)
  );
  imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .CLK(clk), .RESET(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] sel, input logic [31:0] tg);
    in_valid   = v;
    in_instr   = ins;
    in_imm_sel = sel;
    in_tag     = tg;
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    tick(); tick();
    check("rst_valid", 64'(out_valid32), 64'd0);
    check("rst_imm", 64'(out_imm32), 64'd0);
    check("rst_tag", 64'(out_tag32), 64'd0);
    check("rst_ready", 64'(in_ready32), 64'd0);
    check("rst_valid64", 64'(out_valid64), 64'd0);
    rst = 1'b0; #1;
    check("rel_ready", 64'(in_ready32), 64'd1);
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 3'd0, 32'h100);
    tick();
    check("i_valid", 64'(out_valid32), 64'd1);
    check("i_imm", 64'(out_imm32), 64'hFFFFFFFF);
    check("i_tag", 64'(out_tag32), 64'h100);
    check("i_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFF);
    drive(1'b1, 32'hFE000EE3, 3'd2, 32'h2);
    tick();
    check("b_valid", 64'(out_valid32), 64'd1);
    check("b_imm", 64'(out_imm32), 64'hFFFFFFFC);
    drive(1'b1, 32'h340FD073, 3'd5, 32'h3);
    tick();
    check("z_valid", 64'(out_valid32), 64'd1);
    check("z_imm", 64'(out_imm32), 64'h1F);
    drive(1'b1, 32'hFE112E23, 3'd1, 32'h4);
    tick();
    check("s_imm", 64'(out_imm32), 64'hFFFFFFFC);
    drive(1'b1, 32'hFFDFF0EF, 3'd4, 32'h5);
    tick();
    check("j_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFC);
    drive(1'b1, 32'hFFFFFFFF, 3'd7, 32'h6);
    tick();
    check("none_imm", 64'(out_imm32), 64'd0);
    drive(1'b1, 32'h80000537, 3'd3, 32'h7);
    tick();
    check("u_imm32", 64'(out_imm32), 64'h80000000);
    check("u_imm64", out_imm64, 64'hFFFFFFFF80000000);
    drive(1'b1, 32'h03F01093, 3'd6, 32'h8);
    tick();
    check("sh_imm32", 64'(out_imm32), 64'h1F);
    check("sh_imm64", out_imm64, 64'h3F);
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    tick();
    check("drain_valid", 64'(out_valid32), 64'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd0, 32'h1);
    tick();
    check("bp_a_tag", 64'(out_tag32), 64'h1);
    check("bp_a_ready", 64'(in_ready32), 64'd1);
    drive(1'b1, 32'h00200093, 3'd0, 32'h2);
    tick();
    check("bp_skid_ready", 64'(in_ready32), 64'd0);
    check("bp_a_hold", 64'(out_tag32), 64'h1);
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    tick();
    check("bp_a_stable_tag", 64'(out_tag32), 64'h1);
    check("bp_a_stable_imm", 64'(out_imm32), 64'h1);
    out_ready = 1'b1;
    tick();
    check("bp_b_valid", 64'(out_valid32), 64'd1);
    check("bp_b_tag", 64'(out_tag32), 64'h2);
    check("bp_b_imm", 64'(out_imm32), 64'h2);
    check("bp_b_ready", 64'(in_ready32), 64'd1);
    tick();
    check("bp_done_valid", 64'(out_valid32), 64'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h00300093, 3'd0, 32'h3);
    tick();
    drive(1'b1, 32'h00400093, 3'd0, 32'h4);
    tick();
    check("fl_skid_ready", 64'(in_ready32), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h00500093, 3'd0, 32'h5);
    tick();
    flush = 1'b0;
    check("fl_valid", 64'(out_valid32), 64'd0);
    check("fl_ready", 64'(in_ready32), 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h00600093, 3'd0, 32'h6);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    check("fl_acc_dropped", 64'(out_valid32), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fl_quiet", 64'(out_valid32), 64'd0);
    end
    out_ready = 1'b0;
    drive(1'b1, 32'h00700093, 3'd0, 32'h7);
    tick();
    drive(1'b1, 32'h00800093, 3'd0, 32'h8);
    tick();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    rst = 1'b1;
    tick();
    check("mr_valid", 64'(out_valid32), 64'd0);
    check("mr_imm", 64'(out_imm32), 64'd0);
    check("mr_ready", 64'(in_ready32), 64'd0);
    rst = 1'b0; #1;
    check("mr_rel_ready", 64'(in_ready32), 64'd1);
    out_ready = 1'b1;
    drive(1'b1, 32'h00500093, 3'd0, 32'h9);
    tick();
    check("mr_new_valid", 64'(out_valid32), 64'd1);
    check("mr_new_imm", 64'(out_imm32), 64'h5);
    check("mr_new_tag", 64'(out_tag32), 64'h9);
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    tick();
    check("mr_no_stale", 64'(out_valid32), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
